storage_spi_master: RTL and testbench
=====================================

Name: storage_spi_master

Overview:
SPI mode-0 master that executes single-word transactions on the external storage serial flash on behalf of storage_controller (its memory-side front end).
Accepts one request per valid/ready handshake:
- Read: serialises READ opcode + 24-bit address, then shifts in 32 data bits.
- Write: issues a WREN frame, then a PAGE PROGRAM frame with 32 data bits.
Drives external_storage_spi_* pins when the controller is not in programming mode; returns one response pulse per request.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period (>=1)
CS_GAP, 2, minimum clk cycles cs_n held high between frames (>=1)
READ_OPCODE, 8'h03, read-data command
PP_OPCODE, 8'h02, page-program command
WREN_OPCODE, 8'h06, write-enable command

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  24  flash byte address, sent MSB first
req_wdata  in  32  write word, sent MSB first
abort  in  1  synchronous cancel (programming-mode entry)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  read word (0 for writes), valid with rsp_valid
spi_cs_n  out  1  chip select, active low
spi_sck  out  1  serial clock, idle low
spi_mosi  out  1  master out
spi_miso  in  1  master in

Behaviour:
- Reset (rst=0, async) values:
  - state IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - rsp_valid=0, rsp_rdata=0, req_ready=1.
  - all counters 0.
- States: IDLE, WREN, WGAP, FRAME, DONE, GAP.
- Handshake:
  - Accept on any edge with req_valid & req_ready.
  - req_write, req_addr and req_wdata are registered at accept; later input changes are ignored.
  - req_ready=1 only in IDLE. req_valid outside IDLE is ignored with no side effects.
- Accept transitions:
  - Read: IDLE -> FRAME.
  - Write: IDLE -> WREN.
  - On the accept edge: spi_cs_n=0, spi_sck=0, spi_mosi = first bit, divider cleared.
- SCK generation:
  - spi_sck toggles every CLK_DIV clks while in WREN or FRAME.
  - Rising edge: sample spi_miso into the shift register.
  - Falling edge: advance the bit counter and present the next MOSI bit. MOSI is therefore stable a full half-period before each rising edge.
- WREN: 8 bits, WREN_OPCODE MSB first.
  - After the 8th falling edge: spi_cs_n=1, go to WGAP.
  - WGAP holds for CS_GAP clks, then enters FRAME (cs_n=0).
- FRAME: 64 bits.
  - Bits 0-7: opcode (READ_OPCODE or PP_OPCODE).
  - Bits 8-31: req_addr[23:0].
  - Bits 32-63: read sends mosi=0 and shifts in MISO; write sends req_wdata[31:0].
- Completion, on the falling edge of bit 63:
  - spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - rsp_valid=1 for exactly one cycle (DONE).
  - rsp_rdata = shifted word (reads) or 0 (writes); it holds until the next rsp_valid.
- Latency:
  - Read: rsp_valid is high in the cycle after edge accept+128*CLK_DIV (257th cycle after accept for CLK_DIV=2).
  - Write: 16*CLK_DIV + CS_GAP + 128*CLK_DIV cycles after accept.
- DONE -> GAP: spi_cs_n stays 1 for CS_GAP clks, then IDLE with req_ready=1.
  - Minimum back-to-back spacing = latency + 1 + CS_GAP.
- The block does not poll the flash WIP status; flash busy-wait is the controller's responsibility.
- abort=1 in any state:
  - Next edge forces IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - No rsp_valid for the cancelled request; rsp_rdata is unchanged.
  - abort takes priority over a same-cycle accept: no accept occurs.
  - abort held high keeps req_ready=0.
- Reset mid-frame: immediate return to reset values; no response.

Decomposition:
- Package storage_spi_pkg holds:
  - opcode localparams (READ, PP, WREN);
  - state enum type;
  - frame length constants (CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32).
- One sub-module, spi_sck_divider: counter with clear/enable, outputs the sck level plus one-cycle rise_strb and fall_strb.

Test Plan:
- Read, CLK_DIV=2: req addr 24'h001001, miso model returns 32'h12345678 MSB first.
  - MOSI at the 32 rising edges = 8'h03 then 24'h001001.
  - rsp_valid pulses once, 257 cycles after accept, with rsp_rdata=32'h12345678.
- Write: addr 24'h000200, wdata 32'hDEADBEEF.
  - 8-bit frame 8'h06, then cs_n high >= 2 clks.
  - Second frame carries 8'h02, 24'h000200, 32'hDEADBEEF.
  - rsp_valid with rsp_rdata=0.
- Back-to-back reads with req_valid held: the second accept occurs exactly CS_GAP+1 cycles after rsp_valid. cs_n is never low across the gap.
- req_valid with new addr 24'hABCDEF mid-frame: ignored, req_ready=0, the in-flight frame is unaltered.
- abort at bit 20 of a read: next cycle cs_n=1, sck=0, mosi=0, req_ready=1; no rsp_valid ever issued for that request.
- rst=0 asynchronously during the data phase: outputs reach reset values before the next clk edge. A new read after rst=1 completes normally.

Source files
------------

// File: rtl/storage_spi_pkg.sv
// storage_spi_pkg: opcodes, frame geometry and FSM state type for the storage flash SPI master
package storage_spi_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_WREN = 8'h06;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DATA_BITS  = 32;
    localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

    typedef enum logic [2:0] {IDLE, WREN, WGAP, FRAME, DONE, GAP} state_t;

endpackage

// File: rtl/storage_spi_master_spi_sck_divider.sv
// spi_sck_divider: SCK generator; toggles every CLK_DIV clks and flags the edge about to happen
module spi_sck_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sck,
    output logic rise_strb,
    output logic fall_strb
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick      = en && !clr && (cnt == CW'(CLK_DIV - 1));
    assign rise_strb = tick && !sck;
    assign fall_strb = tick && sck;

    // half-period counter; sck flips whenever the counter wraps, clear parks sck low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            sck <= sck ^ tick;
        end
    end

endmodule

// File: rtl/storage_spi_master.sv
// storage_spi_master: SPI mode-0 master running single-word read / WREN+page-program transactions
module storage_spi_master
    import storage_spi_pkg::*;
#(
    parameter int         CLK_DIV     = 2,
    parameter int         CS_GAP      = 2,
    parameter logic [7:0] READ_OPCODE = OP_READ,
    parameter logic [7:0] PP_OPCODE   = OP_PP,
    parameter logic [7:0] WREN_OPCODE = OP_WREN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        abort,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int GW = $clog2(CS_GAP + 1);

    state_t                    state;
    logic                      ready_q;
    logic                      write_q;
    logic [ADDR_BITS-1:0]      addr_q;
    logic [DATA_BITS-1:0]      wdata_q;
    logic [FRAME_BITS-1:0]     tx;
    logic [DATA_BITS-1:0]      rx;
    logic [5:0]                bit_cnt;
    logic [GW-1:0]             gap_cnt;
    logic                      active;
    logic                      rise_strb;
    logic                      fall_strb;

    // abort wins over a same-cycle accept, so it also masks ready
    assign req_ready = ready_q && !abort;
    assign active    = (state == WREN) || (state == FRAME);

    spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort || !active),
        .en        (active),
        .sck       (spi_sck),
        .rise_strb (rise_strb),
        .fall_strb (fall_strb)
    );

    // transaction FSM: frame sequencing, MOSI shifting, MISO capture and response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (rise_strb)
                rx <= {rx[DATA_BITS-2:0], spi_miso};
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        ready_q  <= 1'b0;
                        spi_cs_n <= 1'b0;
                        bit_cnt  <= '0;
                        tx       <= req_write ? {WREN_OPCODE, {(FRAME_BITS-CMD_BITS){1'b0}}}
                                              : {READ_OPCODE, req_addr, {DATA_BITS{1'b0}}};
                        spi_mosi <= req_write ? WREN_OPCODE[7] : READ_OPCODE[7];
                        state    <= req_write ? WREN : FRAME;
                    end
                end
                WREN: begin
                    if (fall_strb) begin
                        if (bit_cnt == 6'(CMD_BITS - 1)) begin
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= WGAP;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx       <= tx << 1;
                            spi_mosi <= tx[FRAME_BITS-2];
                        end
                    end
                end
                WGAP: begin
                    if (gap_cnt == GW'(CS_GAP - 1)) begin
                        spi_cs_n <= 1'b0;
                        bit_cnt  <= '0;
                        tx       <= {PP_OPCODE, addr_q, wdata_q};
                        spi_mosi <= PP_OPCODE[7];
                        state    <= FRAME;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                FRAME: begin
                    if (fall_strb) begin
                        if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                            spi_cs_n  <= 1'b1;
                            spi_mosi  <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= write_q ? '0 : rx;
                            state     <= DONE;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx       <= tx << 1;
                            spi_mosi <= tx[FRAME_BITS-2];
                        end
                    end
                end
                DONE: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GW'(CS_GAP - 1)) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_storage_spi_master.sv
// tb_storage_spi_master: scoreboard bench with a flash slave model for storage_spi_master
`timescale 1ns/1ps
module tb_storage_spi_master;

    localparam int CS_GAP = 2;
    localparam int RD_LAT = 257;
    localparam int WR_LAT = 291;

    typedef struct {
        logic [31:0] d;
        int          lat;
    } rsp_t;

    typedef struct {
        int          n;
        logic [63:0] v;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        abort = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          acc_n = 0;
    int          last_rsp = 0;
    int          gap_meas = 0;
    int          nbits = 0;
    logic [63:0] cap = '0;
    logic [31:0] miso_word = '0;
    longint      t_rise = 0;
    rsp_t        rq[$];
    frame_t      fq[$];

    storage_spi_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .abort     (abort),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // flash slave: MOSI captured on SCK rise, data word driven during bits 32..63
    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (!spi_sck) begin
            cap   = '0;
            nbits = 0;
        end else begin
            cap   = {cap[62:0], spi_mosi};
            nbits = nbits + 1;
        end
    end

    assign spi_miso = (nbits >= 32 && nbits < 64) ? miso_word[5'(63 - nbits)] : 1'b0;

    // frame monitor: each completed or cut frame is checked against the expected bits
    always @(posedge spi_cs_n) begin
        t_rise = $time;
        if (nbits > 0) begin
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got %0d bits %h, required no frame", nbits, cap);
            end else begin
                frame_t f;
                f = fq.pop_front();
                if (f.n != 0) begin
                    checks++;
                    if (f.n != nbits || f.v !== cap) begin
                        errors++;
                        $display("FAIL frame: got %0d bits %h, required %0d bits %h", nbits, cap, f.n, f.v);
                    end
                end
            end
        end
    end

    // chip-select gap monitor: cs_n must stay high at least CS_GAP clks between frames
    always @(negedge spi_cs_n) begin
        checks++;
        if ($time - t_rise < longint'(CS_GAP * 10)) begin
            errors++;
            $display("FAIL cs_gap: got %0d ns high, required >= %0d ns", $time - t_rise, CS_GAP * 10);
        end
    end

    // response monitor: pops the scoreboard on every rsp_valid and checks data and latency
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            gap_meas = cyc - last_rsp;
            acc_cyc  = cyc;
            acc_n    = acc_n + 1;
        end
        if (rsp_valid) begin
            last_rsp = cyc;
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid with %h, required none", rsp_rdata);
            end else begin
                rsp_t e;
                e = rq.pop_front();
                if (rsp_rdata !== e.d || cyc - acc_cyc != e.lat) begin
                    errors++;
                    $display("FAIL rsp: got data %h latency %0d, required data %h latency %0d",
                             rsp_rdata, cyc - acc_cyc, e.d, e.lat);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, required DUT progress", name);
    endtask

    task automatic issue(input logic w, input logic [23:0] a, input logic [31:0] d);
        int n = 0;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) timeout_fail("accept");
        step();
        req_valid = 1'b0;
        req_addr  = 24'hFFFFFF;
        req_wdata = 32'hFFFFFFFF;
        req_write = ~w;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((rq.size() != 0 || !req_ready) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) timeout_fail("completion");
    endtask

    task automatic wait_bits(input int b);
        int n = 0;
        while (nbits < b && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) timeout_fail("bit_wait");
    endtask

    task automatic check_idle_pins(input string tag);
        chk({tag, "_cs_n"}, 32'(spi_cs_n), 32'd1);
        chk({tag, "_sck"}, 32'(spi_sck), 32'd0);
        chk({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int a0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check_idle_pins("reset");
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);

        miso_word = 32'h12345678;
        fq.push_back('{64, {8'h03, 24'h001001, 32'h0}});
        rq.push_back('{32'h12345678, RD_LAT});
        issue(1'b0, 24'h001001, 32'h0);
        wait_done();

        miso_word = 32'h0;
        fq.push_back('{8, 64'h06});
        fq.push_back('{64, {8'h02, 24'h000200, 32'hDEADBEEF}});
        rq.push_back('{32'h0, WR_LAT});
        issue(1'b1, 24'h000200, 32'hDEADBEEF);
        wait_done();

        miso_word = 32'h89ABCDEF;
        for (int i = 0; i < 2; i++) begin
            fq.push_back('{64, {8'h03, 24'h000ABC, 32'h0}});
            rq.push_back('{32'h89ABCDEF, RD_LAT});
        end
        a0 = acc_n;
        req_write = 1'b0;
        req_addr  = 24'h000ABC;
        req_valid = 1'b1;
        for (int n = 0; acc_n < a0 + 2 && n < 1000; n++) step();
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_n - a0), 32'd2);
        chk("b2b_gap", 32'(gap_meas), 32'(CS_GAP + 1));
        wait_done();

        miso_word = 32'hCAFEF00D;
        fq.push_back('{64, {8'h03, 24'h123456, 32'h0}});
        rq.push_back('{32'hCAFEF00D, RD_LAT});
        issue(1'b0, 24'h123456, 32'h0);
        repeat (30) step();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 24'hABCDEF;
        for (int i = 0; i < 4; i++) begin
            chk("midframe_ready", 32'(req_ready), 32'd0);
            step();
        end
        req_valid = 1'b0;
        wait_done();

        miso_word = 32'h55AA55AA;
        fq.push_back('{20, 64'h030F0});
        issue(1'b0, 24'h0F0F0F, 32'h0);
        wait_bits(20);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        check_idle_pins("abort");
        chk("abort_rdata_kept", rsp_rdata, 32'hCAFEF00D);
        repeat (300) step();

        miso_word = 32'hA5A5A5A5;
        issue(1'b0, 24'h00FFFF, 32'h0);
        fq.push_back('{64, {8'h03, 24'h00FFFF, 32'h0}});
        wait_bits(40);
        fq.pop_back();
        fq.push_back('{0, 64'h0});
        #2;
        rst = 1'b0;
        #1;
        check_idle_pins("async_rst");
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_rdata", rsp_rdata, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();

        miso_word = 32'h0F1E2D3C;
        fq.push_back('{64, {8'h03, 24'h000010, 32'h0}});
        rq.push_back('{32'h0F1E2D3C, RD_LAT});
        issue(1'b0, 24'h000010, 32'h0);
        wait_done();
        repeat (10) step();

        chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
        chk("frame_queue_empty", 32'(fq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
